// File: rtl/kgp_risc_pkg.sv
// Shared KGP_RISC definitions: branch-condition encodings, flag bit positions
// in flags_o, and the branch-condition evaluator.
package kgp_risc_pkg;

  typedef enum logic [2:0] {
    BR_ALWAYS = 3'b000,
    BR_ZERO   = 3'b001,
    BR_NZERO  = 3'b010,
    BR_CARRY  = 3'b011,
    BR_NCARRY = 3'b100,
    BR_NEG    = 3'b101,
    BR_GT     = 3'b110,
    BR_OVF    = 3'b111
  } br_cond_e;

  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  // BR_GT is "strictly positive": neither negative nor zero.
  function automatic logic brEval(input logic [2:0] cond, input logic [3:0] f);
    case (br_cond_e'(cond))
      BR_ALWAYS: return 1'b1;
      BR_ZERO:   return f[FLAG_Z];
      BR_NZERO:  return !f[FLAG_Z];
      BR_CARRY:  return f[FLAG_C];
      BR_NCARRY: return !f[FLAG_C];
      BR_NEG:    return f[FLAG_N];
      BR_GT:     return !f[FLAG_N] && !f[FLAG_Z];
      BR_OVF:    return f[FLAG_V];
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_flag_wb_unit_if.sv
// ALU result/flag bus between the ALU/pipeline side (master) and the
// flag + writeback unit (slave), including the register-file writeback port.
interface alu_flag_wb_unit_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [DATA_W-1:0] res;
  logic              carryFlag;
  logic              zeroFlag;
  logic              negFlag;
  logic              overflowFlag;
  logic              updateCarry;
  logic              flag_en;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr_i;
  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [REG_AW-1:0] wb_addr;
  logic              cin;
  logic [3:0]        flags_o;
  logic [2:0]        br_cond;
  logic              br_taken;

  modport master (
    output alu_valid, res, carryFlag, zeroFlag, negFlag, overflowFlag,
           updateCarry, flag_en, wb_en, wb_addr_i, wb_ready, br_cond,
    input  alu_ready, wb_valid, wb_data, wb_addr, cin, flags_o, br_taken
  );

  modport slave (
    input  alu_valid, res, carryFlag, zeroFlag, negFlag, overflowFlag,
           updateCarry, flag_en, wb_en, wb_addr_i, wb_ready, br_cond,
    output alu_ready, wb_valid, wb_data, wb_addr, cin, flags_o, br_taken
  );
endinterface

// File: rtl/wb_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO, no bypass: a pushed entry reaches
// the head on the following cycle. DEPTH must be a power of two, >= 2.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + 1'b1;
    if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
    if (doPush && !doPop)      count_d = count_q + 1'b1;
    else if (doPop && !doPush) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_flag_wb_unit.sv
// Consumer of ALU results: maintains the C/Z/N/V flag register, feeds carry
// back to the ALU, decodes branch conditions and buffers regfile writebacks.
module alu_flag_wb_unit
  import kgp_risc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2
) (
  input logic               clk,
  input logic               rst,
  alu_flag_wb_unit_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [3:0]               flags_q, flags_d;
  logic                     accept, push, pop, full, empty;
  logic [CNT_W-1:0]         count;
  logic [REG_AW+DATA_W-1:0] headEntry;

  // Flag-only ops are also held off while full so flags stay ordered with writebacks.
  assign bus.alu_ready = !full;
  assign accept        = bus.alu_valid && !full;
  assign push          = accept && bus.wb_en;
  assign pop           = bus.wb_ready && (count != '0);

  assign bus.wb_valid  = !empty;
  assign bus.wb_data   = headEntry[DATA_W-1:0];
  assign bus.wb_addr   = headEntry[REG_AW+DATA_W-1:DATA_W];
  assign bus.flags_o   = flags_q;
  assign bus.cin       = flags_q[FLAG_C];
  assign bus.br_taken  = brEval(bus.br_cond, flags_q);

  always_comb begin
    flags_d = flags_q;
    if (accept) begin
      if (bus.flag_en) begin
        flags_d[FLAG_Z] = bus.zeroFlag;
        flags_d[FLAG_N] = bus.negFlag;
        flags_d[FLAG_V] = bus.overflowFlag;
      end
      if (bus.updateCarry) flags_d[FLAG_C] = bus.carryFlag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flags_q <= '0;
    else      flags_q <= flags_d;
  end

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REG_AW + DATA_W)
  ) u_wb_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({bus.wb_addr_i, bus.res}),
    .rdata_o (headEntry),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

endmodule

// File: tb/tb_alu_flag_wb_unit.sv
// Scoreboard bench for alu_flag_wb_unit: directed ALU ops push expected
// writebacks into a queue; a negedge monitor checks every handshaken pop.
module tb_alu_flag_wb_unit;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wbEntry_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   waits;
  wbEntry_t expQ[$];

  alu_flag_wb_unit_if bus ();

  alu_flag_wb_unit #(.DATA_W(32), .REG_AW(5), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [36:0] act, input logic [36:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one op, wait (bounded) for acceptance, return stall cycles.
  task automatic applyStimulus(input logic [31:0] res, input logic c, input logic z,
                               input logic n, input logic v, input logic updC,
                               input logic flagEn, input logic wbEn,
                               input logic [4:0] addr, output int stalls);
    wbEntry_t e;
    if (wbEn) begin
      e.addr = addr;
      e.data = res;
      expQ.push_back(e);
    end
    bus.res          = res;
    bus.carryFlag    = c;
    bus.zeroFlag     = z;
    bus.negFlag      = n;
    bus.overflowFlag = v;
    bus.updateCarry  = updC;
    bus.flag_en      = flagEn;
    bus.wb_en        = wbEn;
    bus.wb_addr_i    = addr;
    bus.alu_valid    = 1'b1;
    stalls = 0;
    @(negedge clk);
    while (!bus.alu_ready && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (!bus.alu_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: alu_ready stayed %0b, expected 1", bus.alu_ready);
    end
    @(posedge clk);
    #1 bus.alu_valid = 1'b0;
  endtask

  // Monitor: every pop the DUT will perform at the next edge is compared.
  always @(negedge clk) begin
    if (rst && bus.wb_valid && bus.wb_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pop: got data %0h, expected no entry", bus.wb_data);
      end else begin
        wbEntry_t e;
        e = expQ.pop_front();
        checkOutput("wb_data", 37'(bus.wb_data), 37'(e.data));
        checkOutput("wb_addr", 37'(bus.wb_addr), 37'(e.addr));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  logic brExp [8];

  initial begin
    rst = 1'b0;
    bus.alu_valid = 1'b0; bus.res = '0; bus.carryFlag = 1'b0; bus.zeroFlag = 1'b0;
    bus.negFlag = 1'b0; bus.overflowFlag = 1'b0; bus.updateCarry = 1'b0;
    bus.flag_en = 1'b0; bus.wb_en = 1'b0; bus.wb_addr_i = '0;
    bus.wb_ready = 1'b0; bus.br_cond = 3'b000;

    // 1. Reset
    #3;
    checkOutput("rst_br_always", 37'(bus.br_taken), 37'd1);
    checkOutput("rst_alu_ready", 37'(bus.alu_ready), 37'd1);
    #9 rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_alu_ready", 37'(bus.alu_ready), 37'd1);
    checkOutput("post_rst_wb_valid", 37'(bus.wb_valid), 37'd0);
    checkOutput("post_rst_cin", 37'(bus.cin), 37'd0);
    checkOutput("post_rst_flags", 37'(bus.flags_o), 37'b0000);
    bus.br_cond = 3'b010; #1;
    checkOutput("post_rst_br_nz", 37'(bus.br_taken), 37'd1);

    // 2. Single op
    bus.wb_ready = 1'b1;
    applyStimulus(32'hFF3D0692, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, waits);
    checkOutput("single_wb_valid", 37'(bus.wb_valid), 37'd1);
    checkOutput("single_flags", 37'(bus.flags_o), 37'b0010);
    bus.br_cond = 3'b101; #1;
    checkOutput("single_br_neg", 37'(bus.br_taken), 37'd1);
    bus.br_cond = 3'b110; #1;
    checkOutput("single_br_gt", 37'(bus.br_taken), 37'd0);
    @(posedge clk); #1;
    checkOutput("single_drained", 37'(bus.wb_valid), 37'd0);

    // 3. Backpressure
    bus.wb_ready = 1'b0;
    applyStimulus(32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, waits);
    applyStimulus(32'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, waits);
    checkOutput("bp_full_ready", 37'(bus.alu_ready), 37'd0);
    checkOutput("bp_head_stable", 37'(bus.wb_data), 37'h1);
    fork
      applyStimulus(32'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, waits);
      begin
        @(posedge clk);
        #1 bus.wb_ready = 1'b1;
      end
    join
    checkOutput("bp_third_stalls", 37'(waits), 37'd2);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp_drained", 37'(bus.wb_valid), 37'd0);
    checkOutput("bp_queue_empty", 37'(expQ.size()), 37'd0);
    checkOutput("bp_flags_held", 37'(bus.flags_o), 37'b0010);

    // 4. Carry gating
    applyStimulus(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, waits);
    checkOutput("carry_gated_cin", 37'(bus.cin), 37'd0);
    applyStimulus(32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, waits);
    checkOutput("carry_upd_cin", 37'(bus.cin), 37'd1);
    checkOutput("carry_upd_flags", 37'(bus.flags_o), 37'b1010);

    // 5. Flag-only op while full
    bus.wb_ready = 1'b0;
    applyStimulus(32'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, waits);
    applyStimulus(32'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, waits);
    bus.zeroFlag = 1'b1; bus.negFlag = 1'b0; bus.overflowFlag = 1'b0;
    bus.carryFlag = 1'b0; bus.updateCarry = 1'b0; bus.flag_en = 1'b1;
    bus.wb_en = 1'b0; bus.alu_valid = 1'b1;
    @(negedge clk);
    checkOutput("full_blocks_flagop", 37'(bus.alu_ready), 37'd0);
    @(posedge clk); #1;
    checkOutput("full_z_held", 37'(bus.flags_o), 37'b1010);
    bus.wb_ready = 1'b1;
    @(posedge clk); #1;
    bus.wb_ready = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, waits);
    checkOutput("flagop_no_stall", 37'(waits), 37'd0);
    checkOutput("flagop_flags", 37'(bus.flags_o), 37'b1100);
    checkOutput("flagop_cnt1_valid", 37'(bus.wb_valid), 37'd1);
    checkOutput("flagop_cnt1_ready", 37'(bus.alu_ready), 37'd1);

    // Full branch decode with C=1 Z=1 N=0 V=0
    brExp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      bus.br_cond = 3'(i);
      #1;
      checkOutput($sformatf("br_decode_%0d", i), 37'(bus.br_taken), 37'(brExp[i]));
    end
    @(posedge clk); #1;

    // 6. Async reset mid-drain
    applyStimulus(32'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, waits);
    checkOutput("pre_rst_ready", 37'(bus.alu_ready), 37'd0);
    #1 rst = 1'b0;
    #1;
    checkOutput("async_rst_wb_valid", 37'(bus.wb_valid), 37'd0);
    checkOutput("async_rst_flags", 37'(bus.flags_o), 37'b0000);
    checkOutput("async_rst_ready", 37'(bus.alu_ready), 37'd1);
    expQ.delete();
    @(posedge clk);
    #2 rst = 1'b1;
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("no_stale_wb_valid", 37'(bus.wb_valid), 37'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_flag_wb_unit.md
Name: alu_flag_wb_unit

Overview:
- Consumer end of the ALU result/flag interface in the KGP_RISC datapath.
- Takes each ALU result, updates the architectural flag register (C, Z, N, V) and feeds the carry back to the ALU `cin`.
- Evaluates branch conditions from the registered flags.
- Buffers register-file writebacks in a small FIFO with a valid/ready handshake toward the register file.

Parameters:
- DATA_W, 32, ALU result width.
- REG_AW, 5, register-file address width.
- DEPTH, 2, writeback FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result presented this cycle.
- alu_ready  out  1  unit can accept (FIFO not full).
- res  in  DATA_W  ALU result.
- carryFlag / zeroFlag / negFlag / overflowFlag  in  1 each  ALU flags.
- updateCarry  in  1  this op may modify C.
- flag_en  in  1  this op may modify Z, N, V.
- wb_en  in  1  result is to be written to the register file.
- wb_addr_i  in  REG_AW  destination register.
- wb_valid  out  1  FIFO head valid.
- wb_ready  in  1  register file consumes the head.
- wb_data  out  DATA_W  FIFO head data.
- wb_addr  out  REG_AW  FIFO head address.
- cin  out  1  registered C, fed to the ALU carry-in.
- flags_o  out  4  {C,Z,N,V}, registered.
- br_cond  in  3  branch condition select.
- br_taken  out  1  condition result, combinational from the registered flags.

Behaviour:
- Reset (rst=0, asynchronous): C=Z=N=V=0; FIFO pointers=0, count=0.
  - Outputs during reset: wb_valid=0, cin=0, flags_o=0, alu_ready=1.
  - br_taken reflects the zero flags (e.g. br_cond=000 → 1).
- Accept: the cycle where alu_valid && alu_ready.
  - alu_ready = (count != DEPTH), derived from registered state only. No combinational path from wb_ready.
  - Flag-only ops (wb_en=0) are also gated by alu_ready, so flag updates stay ordered with writebacks.
- Flag update on accept, visible the next cycle:
  - If flag_en: Z<=zeroFlag, N<=negFlag, V<=overflowFlag.
  - If updateCarry: C<=carryFlag, independent of flag_en.
  - Flags not enabled hold their value.
  - No accept: all flags hold.
- FIFO:
  - Push on accept with wb_en=1.
  - Pop when wb_valid && wb_ready.
  - wb_valid = (count != 0). wb_data/wb_addr present the head entry; their value is unspecified when wb_valid=0.
  - Simultaneous push and pop: count unchanged and both pointers advance. This can occur only when not full.
  - Pointers wrap modulo DEPTH.
  - Ordering: strict FIFO. An entry pushed in cycle t is at the head no earlier than t+1 (latency 1, no bypass).
  - wb_data/wb_addr stay stable while wb_valid=1 and wb_ready=0.
- br_taken decode (flags as registered):
  - 000 always
  - 001 Z
  - 010 !Z
  - 011 C
  - 100 !C
  - 101 N
  - 110 !N && !Z
  - 111 V
- Hazard rule: a branch evaluated in the same cycle as the accept of its flag-setting op sees the old flags. The pipeline control owns the one-cycle stall; this unit does no forwarding.
- Reset mid-operation: all buffered entries are discarded immediately and nothing is drained.

Decomposition:
- Shared package (kgp_risc_pkg) holds:
  - the br_cond encodings as named constants (BR_ALWAYS … BR_OVF);
  - the flag bit positions in flags_o (FLAG_C=3, FLAG_Z=2, FLAG_N=1, FLAG_V=0).
- One sub-module, `wb_fifo`: generic DEPTH × (DATA_W+REG_AW) synchronous FIFO.
  - Interface: push/pop/full/empty/count.
  - Same active-low async reset.
- Flag register and branch decode live in the top module.

Test Plan:
1. Reset: hold rst=0, then release → alu_ready=1, wb_valid=0, cin=0, flags_o=4'b0000; br_cond=010 → br_taken=1.
2. Single op: accept res=32'hFF3D0692, N=1, Z=0, V=0, C=0, flag_en=1, updateCarry=1, wb_en=1, wb_addr_i=3, wb_ready=1.
   - Next cycle: wb_valid=1, wb_data=32'hFF3D0692, wb_addr=3, flags_o=4'b0010.
   - br_cond=101 → br_taken=1; br_cond=110 → br_taken=0.
   - Entry popped that cycle.
3. Backpressure with wb_ready=0: offer three ops with res 32'h1, 32'h2, 32'h3.
   - First two accepted; alu_ready=0 after the second, so the third stalls.
   - Raise wb_ready=1 → data 1, 2, 3 drain in order.
   - The third op is accepted the cycle after the first pop.
4. Carry gating:
   - Accept carryFlag=1, updateCarry=0 → cin stays 0.
   - Accept carryFlag=1, updateCarry=1, flag_en=0 → cin=1 next cycle; Z/N/V unchanged.
5. Flag-only op while full: wb_en=0, zeroFlag=1, flag_en=1, FIFO full → not accepted and Z stays 0. After one pop it is accepted → Z=1; count returns to 1 with no push.
6. Async reset mid-drain: FIFO holding 2 entries, assert rst=0 between clock edges → wb_valid=0 and flags_o=0 immediately. After release, no stale data: wb_valid stays 0.
